eeprom_seq: RTL and testbench

Synthesizable, parametrised transaction sequencer for the EEPROM read/write converter. It replays a loadable table of (address, data) entries as WR strobes, reads them back with RD strobes, and compares the returned bytes in hardware. Each transaction is handshaked on the converter's ACK. It reports a mismatch count, the first failing index and an ACK-timeout flag.

---
 rtl/eeprom_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_eeprom_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_seq.sv
// eeprom_seq: replays a loadable (address, data) table to the EEPROM converter
// as WR strobes, reads the entries back with RD strobes and compares the
// returned bytes, handshaking every transaction on the rising edge of ACK.
module eeprom_seq #(
  parameter int  ADDR_W      = 11,
  parameter int  DATA_W      = 8,
  parameter int  DEPTH       = 16,
  parameter int  GAP_CYC     = 5,
  parameter int  PULSE_CYC   = 1,
  parameter int  PHASE_GAP   = 10,
  parameter int  TIMEOUT_CYC = 4096,
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              tbl_we,
  input  logic [IW-1:0]     tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IW:0]       count,
  input  logic              ACK,
  output logic              WR,
  output logic              RD,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [IW:0]       err_cnt,
  output logic              err_valid,
  output logic [IW-1:0]     err_idx
);

  // One shared cycle counter serves every timed state, so size it for the longest.
  localparam int MAX_A = (GAP_CYC > PULSE_CYC) ? GAP_CYC : PULSE_CYC;
  localparam int MAX_B = (PHASE_GAP > TIMEOUT_CYC) ? PHASE_GAP : TIMEOUT_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    STROBE,
    WAIT_ACK,
    PHASE,
    DONE
  } state_t;

  // Mismatch counter sticks at all-ones instead of wrapping.
  function automatic logic [IW:0] sat_inc(input logic [IW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True in the last cycle of an n-cycle interval counted from zero.
  function automatic logic elapsed(input logic [CW-1:0] c, input int n);
    return (int'(c) + 1 >= n);
  endfunction

  logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [DATA_W-1:0] tbl_data_q [DEPTH];

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_phase_q, wr_phase_d;
  logic              verify_q, verify_d;
  logic [IW:0]       count_q, count_d;
  logic              ack_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              timeout_q, timeout_d;
  logic [IW:0]       err_cnt_q, err_cnt_d;
  logic              err_valid_q, err_valid_d;
  logic [IW-1:0]     err_idx_q, err_idx_d;
  logic              ack_rise;
  logic              load;

  // A level-high ACK only counts on the cycle it first rises.
  assign ack_rise = ACK & ~ack_q;

  // Transaction table: loadable only while idle and deliberately kept across RESET.
  always_ff @(posedge CLK) begin
    if (tbl_we && (state_q == IDLE)) begin
      tbl_addr_q[tbl_idx] <= tbl_addr;
      tbl_data_q[tbl_idx] <= tbl_data;
    end
  end

  // Control, bus and result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      wr_phase_q  <= 1'b0;
      verify_q    <= 1'b0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wr_phase_q  <= wr_phase_d;
      verify_q    <= verify_d;
      count_q     <= count_d;
      ack_q       <= ACK;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      err_idx_q   <= err_idx_d;
    end
  end

  // Next-state logic: sequencing, read-back compare and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + 1'b1;
    wr_phase_d  = wr_phase_q;
    verify_d    = verify_q;
    count_d     = count_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    err_idx_d   = err_idx_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (count != '0) begin
            state_d     = GAP;
            idx_d       = '0;
            wr_phase_d  = (mode != 2'b01);
            verify_d    = mode[1];
            count_d     = count;
            load        = 1'b1;
            timeout_d   = 1'b0;
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
            err_idx_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (elapsed(cnt_q, GAP_CYC)) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (elapsed(cnt_q, PULSE_CYC)) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          cnt_d = '0;
          // DATA_IN is only guaranteed valid in the ACK-rise cycle, so compare now.
          if (!wr_phase_q && (DATA_IN != tbl_data_q[idx_q])) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              err_idx_d   = idx_q;
            end
          end
          if ({1'b0, idx_q} == count_q - 1'b1) begin
            state_d = (wr_phase_q && verify_q) ? PHASE : DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
            load    = 1'b1;
          end
        end else if (elapsed(cnt_q, TIMEOUT_CYC)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
      end
      PHASE: begin
        if (elapsed(cnt_q, PHASE_GAP)) begin
          state_d    = GAP;
          wr_phase_d = 1'b0;
          idx_d      = '0;
          load       = 1'b1;
          cnt_d      = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus values are captured on GAP entry and then held until WAIT_ACK is left.
    if (load) begin
      addr_d = tbl_addr_q[idx_d];
      if (wr_phase_d) begin
        dout_d = tbl_data_q[idx_d];
      end
    end
  end

  // Strobes decode straight from state so RESET drops them without waiting for a clock.
  assign WR        = (state_q == STROBE) && wr_phase_q;
  assign RD        = (state_q == STROBE) && !wr_phase_q;
  assign DATA_OE   = wr_phase_q && ((state_q == GAP) || (state_q == STROBE) ||
                                    (state_q == WAIT_ACK));
  assign ADDR      = addr_q;
  assign DATA_OUT  = dout_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign err_cnt   = err_cnt_q;
  assign err_valid = err_valid_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_eeprom_seq.sv
// tb_eeprom_seq: directed bench for eeprom_seq with a behavioural EEPROM
// converter model that echoes written data and can corrupt, delay or drop ACKs.
module tb_eeprom_seq;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IW     = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              tbl_we = 1'b0;
  logic [IW-1:0]     tbl_idx = '0;
  logic [ADDR_W-1:0] tbl_addr = '0;
  logic [DATA_W-1:0] tbl_data = '0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [IW:0]       count = '0;
  logic              ACK;
  logic              WR, RD;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DATA_OE;
  logic [DATA_W-1:0] DATA_IN;
  logic              busy, done, timeout;
  logic [IW:0]       err_cnt;
  logic              err_valid;
  logic [IW-1:0]     err_idx;

  eeprom_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYC(5),
    .PULSE_CYC(1), .PHASE_GAP(10), .TIMEOUT_CYC(64)
  ) dut (
    .CLK(CLK), .RESET(RESET), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .start(start), .mode(mode),
    .count(count), .ACK(ACK), .WR(WR), .RD(RD), .ADDR(ADDR),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .busy(busy),
    .done(done), .timeout(timeout), .err_cnt(err_cnt), .err_valid(err_valid),
    .err_idx(err_idx)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  int nassert = 0;
  int nfail = 0;
  logic [ADDR_W-1:0] exp_addr [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];
  logic [DATA_W-1:0] mem [2048];

  // model configuration (written by the stimulus block only)
  int          ack_dly  = 20;
  int          ack_len  = 1;
  int          noack_at = -1;
  bit          spur_en  = 1'b0;
  logic [15:0] corrupt  = '0;
  int          start_cyc = 0;

  // model observations (written by the model only)
  int wr_n = 0, rd_n = 0, done_n = 0, oe_bad = 0;
  int first_wr_cyc = -1, first_rd_cyc = -1, wr_ack_cyc = 0;
  int last_str_end = 0, done_cyc = 0;

  // EEPROM converter model, acting half a cycle away from the DUT clock edge
  initial begin
    int cur_idx, pend, hold, spur_cd;
    bit cur_rd, prev_str, fell, in_spur, str;
    logic [ADDR_W-1:0] cur_addr;
    for (int a = 0; a < 2048; a++) mem[a] = 8'(a) ^ 8'h5A;
    ACK = 1'b0; DATA_IN = '0;
    pend = -1; hold = 0; spur_cd = 0; cur_idx = 0; cur_rd = 1'b0;
    prev_str = 1'b0; in_spur = 1'b0; cur_addr = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (start === 1'b1 && busy === 1'b0) begin
        wr_n = 0; rd_n = 0; done_n = 0; oe_bad = 0;
        first_wr_cyc = -1; first_rd_cyc = -1;
      end
      if (done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
      end
      fell = 1'b0;
      if (ACK) begin
        hold--;
        if (hold <= 0) begin
          ACK = 1'b0;
          fell = 1'b1;
          spur_cd = (spur_en && !in_spur) ? 2 : 0;
          in_spur = 1'b0;
        end
      end
      str = (WR === 1'b1) || (RD === 1'b1);
      if (str && !prev_str) begin
        cur_rd = (RD === 1'b1);
        cur_addr = ADDR;
        if (!cur_rd && DATA_OE !== 1'b1) oe_bad++;
        if (cur_rd && DATA_OE !== 1'b0) oe_bad++;
        if (!cur_rd) begin
          mem[ADDR] = DATA_OUT;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          cur_idx = wr_n;
          wr_n++;
        end else begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          cur_idx = rd_n;
          rd_n++;
        end
        pend = (cur_idx == noack_at) ? -1 : ack_dly;
      end
      if (!str && prev_str) last_str_end = cyc;
      prev_str = str;
      if (pend > 0) pend--;
      if (!ACK && !fell) begin
        if (pend == 0) begin
          ACK = 1'b1;
          hold = ack_len;
          pend = -1;
          spur_cd = 0;
          if (cur_rd) DATA_IN = mem[cur_addr] ^ ((corrupt[cur_idx & 15]) ? 8'hFF : 8'h00);
          else wr_ack_cyc = cyc;
        end else if (spur_cd > 0) begin
          spur_cd--;
          if (spur_cd == 0) begin
            ACK = 1'b1;
            hold = 1;
            in_spur = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_entry(input int i);
    @(negedge CLK);
    tbl_we = 1'b1; tbl_idx = 4'(i); tbl_addr = exp_addr[i]; tbl_data = exp_data[i];
    @(negedge CLK);
    tbl_we = 1'b0;
  endtask

  // launch a sequence and return on the negedge of the DONE cycle
  task automatic run(input logic [1:0] m, input int n, input int budget);
    int k;
    @(negedge CLK);
    mode = m; count = 5'(n); start = 1'b1; start_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  function automatic int mem_bad();
    int b = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[exp_addr[i]] !== exp_data[i]) b++;
    return b;
  endfunction

  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr[i] = 11'h100 + 11'(i * 37);
      exp_data[i] = 8'(i * 29 + 7);
    end

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_rd", 32'(RD), 32'd0);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_dout", 32'(DATA_OUT), 32'd0);
    check("rst_oe", 32'(DATA_OE), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < DEPTH; i++) load_entry(i);

    // count = 0: done on the cycle after start, no strobes
    run(2'b10, 0, 10);
    @(negedge CLK);
    check("cnt0_done_width", 32'(done), 32'd0);
    check("cnt0_idle", 32'(busy), 32'd0);
    settle(30);
    check("cnt0_no_strobes", 32'(wr_n + rd_n), 32'd0);
    check("cnt0_done_pulses", 32'(done_n), 32'd1);

    // mode 10, full table, echoing model
    run(2'b10, 16, 3000);
    check("m10_err_cnt", 32'(err_cnt), 32'd0);
    check("m10_err_valid", 32'(err_valid), 32'd0);
    check("m10_timeout", 32'(timeout), 32'd0);
    settle(40);
    check("m10_wr_n", 32'(wr_n), 32'd16);
    check("m10_rd_n", 32'(rd_n), 32'd16);
    check("m10_done_pulses", 32'(done_n), 32'd1);
    check("m10_oe", 32'(oe_bad), 32'd0);
    check("m10_mem", 32'(mem_bad()), 32'd0);

    // mode 01, corrupt read indices 3 and 9
    corrupt = 16'h0208;
    run(2'b01, 16, 3000);
    check("m01_err_cnt", 32'(err_cnt), 32'd2);
    check("m01_err_idx", 32'(err_idx), 32'd3);
    check("m01_err_valid", 32'(err_valid), 32'd1);
    settle(40);
    corrupt = '0;
    check("m01_rd_n", 32'(rd_n), 32'd16);
    check("m01_wr_n", 32'(wr_n), 32'd0);

    // ACK never arrives for entry 5
    noack_at = 5;
    run(2'b00, 16, 3000);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_addr", 32'(ADDR), 32'(exp_addr[5]));
    check("to_err_cleared", 32'(err_cnt), 32'd0);
    check("to_err_valid", 32'(err_valid), 32'd0);
    settle(40);
    noack_at = -1;
    check("to_latency", 32'(done_cyc - last_str_end), 32'd64);
    check("to_wr_n", 32'(wr_n), 32'd6);
    check("to_done_pulses", 32'(done_n), 32'd1);

    // count = 1 in mode 10: strobe timing and the phase gap
    run(2'b10, 1, 500);
    settle(40);
    check("c1_wr_n", 32'(wr_n), 32'd1);
    check("c1_rd_n", 32'(rd_n), 32'd1);
    check("c1_first_strobe", 32'(first_wr_cyc - start_cyc), 32'd6);
    check("c1_phase_gap", 32'(first_rd_cyc - wr_ack_cyc), 32'd16);
    check("c1_err_cnt", 32'(err_cnt), 32'd0);

    // ACK held high for 50 cycles
    ack_len = 50;
    run(2'b10, 4, 3000);
    check("hold_err_cnt", 32'(err_cnt), 32'd0);
    settle(80);
    ack_len = 1;
    check("hold_wr_n", 32'(wr_n), 32'd4);
    check("hold_rd_n", 32'(rd_n), 32'd4);
    check("hold_done_pulses", 32'(done_n), 32'd1);

    // spurious ACK pulse in every GAP, with fresh data for entries 0..3
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = exp_data[i] ^ 8'hFF;
      load_entry(i);
    end
    spur_en = 1'b1;
    run(2'b10, 4, 3000);
    check("spur_err_cnt", 32'(err_cnt), 32'd0);
    check("spur_err_valid", 32'(err_valid), 32'd0);
    settle(40);
    spur_en = 1'b0;
    check("spur_wr_n", 32'(wr_n), 32'd4);
    check("spur_rd_n", 32'(rd_n), 32'd4);
    check("spur_mem", 32'(mem_bad()), 32'd0);

    // RESET in the middle of a WR strobe
    @(negedge CLK);
    mode = 2'b00; count = 5'd16; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    k = 0;
    while (WR !== 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("rst_mid_saw_wr", 32'(WR), 32'd1);
    RESET = 1'b1;
    #1;
    check("rst_mid_wr", 32'(WR), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_mid_oe", 32'(DATA_OE), 32'd0);
    settle(2);
    RESET = 1'b0;
    settle(80);
    check("rst_mid_no_done", 32'(done_n), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);

    // table retained: read-verify everything
    run(2'b01, 16, 3000);
    check("ret_err_cnt", 32'(err_cnt), 32'd0);
    check("ret_err_valid", 32'(err_valid), 32'd0);
    settle(40);
    check("ret_rd_n", 32'(rd_n), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
